// File: rtl/traffic_phase_scheduler.sv
// Tick-timed highway/country junction sequencer: G->Y->all-red->G for both roads,
// with car-sensor service, latched pedestrian request and an all-red hold override.
//
// state     | meaning
// ----------+---------------------------------------------
// S_HWY_G 0 | highway green, country red
// S_HWY_Y 1 | highway yellow
// S_AR1   2 | all-red clearance before country green
// S_CTY_G 3 | country green (walk lamp if request captured)
// S_CTY_Y 4 | country yellow
// S_AR2   5 | all-red clearance before highway green
// S_HOLD  6 | all-red override while hold is asserted
module traffic_phase_scheduler #(
    parameter int CNT_W         = 4,
    parameter int MIN_HWY_GREEN = 4,
    parameter int Y_TICKS       = 2,
    parameter int AR_TICKS      = 1,
    parameter int MIN_CTY_GREEN = 2,
    parameter int MAX_CTY_GREEN = 6
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       tick,
    input  logic       car_sensor,
    input  logic       ped_req,
    input  logic       hold,
    output logic [1:0] hwy_light,
    output logic [1:0] cty_light,
    output logic       ped_walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_HWY_G = 3'd0,
        S_HWY_Y = 3'd1,
        S_AR1   = 3'd2,
        S_CTY_G = 3'd3,
        S_CTY_Y = 3'd4,
        S_AR2   = 3'd5,
        S_HOLD  = 3'd6
    } state_t;

    localparam logic [1:0] LAMP_RED = 2'd0;
    localparam logic [1:0] LAMP_YEL = 2'd1;
    localparam logic [1:0] LAMP_GRN = 2'd2;

    // Terminal-count values: a phase lasting N ticks exits when timer == N-1.
    localparam logic [CNT_W-1:0] HWY_MIN_TC = CNT_W'(MIN_HWY_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_TC       = CNT_W'(Y_TICKS - 1);
    localparam logic [CNT_W-1:0] AR_TC      = CNT_W'(AR_TICKS - 1);
    localparam logic [CNT_W-1:0] CTY_MIN_TC = CNT_W'(MIN_CTY_GREEN - 1);
    localparam logic [CNT_W-1:0] CTY_MAX_TC = CNT_W'(MAX_CTY_GREEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] timer;
    logic             ped_pending;
    logic             walk_flag;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state       <= S_HWY_G;
            timer       <= '0;
            ped_pending <= 1'b0;
            walk_flag   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                timer <= '0;
            end else if (tick && (timer != '1)) begin
                timer <= timer + 1'b1;
            end
            // A new request on the same edge as the clear must survive.
            if (ped_req) begin
                ped_pending <= 1'b1;
            end else if ((state == S_CTY_G) && (state_nxt == S_CTY_Y)) begin
                ped_pending <= 1'b0;
            end
            if ((state != S_CTY_G) && (state_nxt == S_CTY_G)) begin
                walk_flag <= ped_pending;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (tick) begin
            case (state)
                S_HWY_G: if ((timer >= HWY_MIN_TC) && (car_sensor || ped_pending || hold))
                             state_nxt = S_HWY_Y;
                         else if (hold)
                             state_nxt = S_HWY_Y;
                S_HWY_Y: if (timer == Y_TC) state_nxt = S_AR1;
                S_AR1:   if (timer == AR_TC) state_nxt = hold ? S_HOLD : S_CTY_G;
                S_CTY_G: if (hold || (timer == CTY_MAX_TC) ||
                             ((timer >= CTY_MIN_TC) && !car_sensor))
                             state_nxt = S_CTY_Y;
                S_CTY_Y: if (timer == Y_TC) state_nxt = S_AR2;
                S_AR2:   if (timer == AR_TC) state_nxt = hold ? S_HOLD : S_HWY_G;
                S_HOLD:  if (!hold) state_nxt = S_HWY_G;
                default: state_nxt = S_HWY_G;
            endcase
        end
    end

    always_comb begin
        hwy_light = LAMP_RED;
        cty_light = LAMP_RED;
        case (state)
            S_HWY_G: hwy_light = LAMP_GRN;
            S_HWY_Y: hwy_light = LAMP_YEL;
            S_CTY_G: cty_light = LAMP_GRN;
            S_CTY_Y: cty_light = LAMP_YEL;
            default: ;
        endcase
    end

    assign ped_walk = (state == S_CTY_G) && walk_flag;
    assign phase    = state;

endmodule
